alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Out-of-order reservation station and issue scheduler for the single-cycle ALU execute unit.
- Accepts renamed ALU ops from dispatch, holds them until both source operands have arrived, and tracks operands by ROB index through CDB wakeup.
- Picks the oldest ready entry each cycle and drives it through a registered, stallable issue slot into the ALU.

Parameters:
DEPTH, 8, number of RS entries (power of two, 2..16)
ROB_IDX_W, 5, width of ROB index tags
NUM_CDB, 2, number of CDB broadcast ports snooped for wakeup

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush (mispredict); kills all entries and the issue slot
dispatch_valid  in  1  dispatch offers an op
dispatch_ready  out  1  queue can accept an op this cycle
dispatch_entry  in  reservation_station_t  op payload; rs1_data/rs2_data meaningful only when the matching rdy bit is set
dispatch_rs1_rdy  in  1  rs1 value already present (or unused)
dispatch_rs2_rdy  in  1  rs2 value already present (or unused)
dispatch_rs1_tag  in  ROB_IDX_W  producer ROB index for rs1
dispatch_rs2_tag  in  ROB_IDX_W  producer ROB index for rs2
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_rob_idx  in  NUM_CDB x ROB_IDX_W  broadcast tags
cdb_data  in  NUM_CDB x 32  broadcast values
issue_valid  out  1  issue slot holds an op for the ALU
issue_ready  in  1  downstream (writeback/CDB grant) accepts the op
issue_entry  out  reservation_station_t  op to the ALU with rs1_data/rs2_data resolved and valid set
occupancy  out  $clog2(DEPTH)+1  number of occupied entries (excluding the issue slot)

Behaviour:
- Reset:
  - All entries invalid; age matrix cleared.
  - issue_valid=0, issue_entry='0, occupancy=0.
  - dispatch_ready=1 from the first cycle after reset.
- Dispatch:
  - dispatch_ready = (occupancy < DEPTH), computed from current state only. An entry freed this cycle does not raise dispatch_ready this cycle.
  - On dispatch_valid && dispatch_ready && !flush, write into the lowest-index free entry.
  - For the new entry, mark it younger than every currently valid entry: age[new][j]=0, age[j][new]=1 for all valid j.
- Wakeup:
  - Each cycle, every valid entry with an unready operand compares its tag against every cdb_valid port.
  - On a match, capture cdb_data and set rdy.
  - A dispatching op whose tag matches a same-cycle CDB broadcast captures that data at write (bypass). This avoids a lost wakeup.
  - With multiple matching ports, the lowest port index wins (a legal design never produces this).
- Select:
  - Candidates are valid entries with both rdy bits set, using registered state only.
  - An operand woken this cycle makes its entry eligible next cycle.
  - The grant goes to the candidate with no older candidate (age matrix), so exactly one-hot or none.
- Issue slot (one register stage; ALU sees issue_entry combinationally):
  - Slot loads when (!issue_valid || issue_ready) and a candidate exists. The granted entry is freed in the same edge.
  - Slot clears issue_valid when (issue_valid && issue_ready) and there is no candidate.
  - When issue_valid && !issue_ready, slot and issue_entry hold stable and no entry is freed.
  - Throughput: 1 op/cycle when issue_ready stays high. Minimum latency from dispatch (operands ready) to issue_valid is 2 edges.
- Flush:
  - All entries invalid, issue_valid=0, occupancy=0 at the next edge.
  - Dispatch, wakeup and issue in the flush cycle are discarded.
  - rst has priority over flush.
- Occupancy: +1 on accepted dispatch, -1 on grant, unchanged when both occur. It never exceeds DEPTH or underflows.
- Invariant (bench must check): occupancy equals popcount of entry valid bits.

Decomposition:
- Add to rv32i_types:
  - alu_rs_entry_t: reservation_station_t plus rs1_rdy, rs2_rdy, rs1_tag, rs2_tag.
  - A cdb_t struct (valid, rob_idx, data).
- Sub-module age_matrix_select (parameter DEPTH):
  - Owns the age matrix.
  - Inputs: alloc one-hot, free one-hot, request vector.
  - Output: oldest one-hot grant.
  - Reused later by the load/store and mul/div queues.

Test Plan:
- Ready ops: dispatch 3 ops with both rdy=1 on consecutive cycles, issue_ready=1 -> issue_valid high on cycles 2,3,4 in dispatch order; occupancy peaks at 1.
- Wakeup and age order: dispatch op A (rs1_tag=5 unready), then op B (ready) -> B issues first. cdb_valid[0]=1, rob_idx=5, data=0x1234 -> A issues next cycle with rs1_data=0x1234.
- Same-cycle bypass: dispatch with rs2_tag=9 unready while cdb port 1 broadcasts 9/0xDEAD -> entry issues next cycle with rs2_data=0xDEAD.
- Full/backpressure: issue_ready=0, dispatch 9 ready ops at DEPTH=8 -> first op held in slot, 8 stored, dispatch_ready=0. Release issue_ready -> 9 ops issue oldest-first with issue_entry stable while stalled.
- Flush: 5 entries plus a valid slot, assert flush together with dispatch_valid -> next cycle occupancy=0, issue_valid=0, dispatch_ready=1, dispatched op absent.
- Reset mid-stall: issue_valid=1, issue_ready=0, assert rst -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU reservation station: op payload, queue entry and CDB beat.
// Downstream queues (load/store, mul/div) import the same definitions.
package alu_issue_queue_pkg;

  localparam int XLEN     = 32;
  localparam int RS_TAG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    alu_op_e             op;
    logic [RS_TAG_W-1:0] rob_idx;
    logic [4:0]          rd;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
  } reservation_station_t;

  typedef struct packed {
    reservation_station_t rs;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [RS_TAG_W-1:0]  rs1_tag;
    logic [RS_TAG_W-1:0]  rs2_tag;
  } alu_rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] rob_idx;
    logic [XLEN-1:0]     data;
  } cdb_t;

  function automatic logic cdb_hit(input cdb_t c, input logic [RS_TAG_W-1:0] tag);
    return c.valid && (c.rob_idx == tag);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB snoop, flush and issue-side signals of the ALU issue queue.
// The pipeline side uses the master modport; the queue uses slave.
interface alu_issue_queue_if
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = RS_TAG_W,
  parameter int NUM_CDB   = 2
);
  logic                                flush;
  logic                                dispatch_valid;
  logic                                dispatch_ready;
  reservation_station_t                dispatch_entry;
  logic                                dispatch_rs1_rdy;
  logic                                dispatch_rs2_rdy;
  logic [ROB_IDX_W-1:0]                dispatch_rs1_tag;
  logic [ROB_IDX_W-1:0]                dispatch_rs2_tag;
  logic [NUM_CDB-1:0]                  cdb_valid;
  logic [NUM_CDB-1:0][ROB_IDX_W-1:0]   cdb_rob_idx;
  logic [NUM_CDB-1:0][XLEN-1:0]        cdb_data;
  logic                                issue_valid;
  logic                                issue_ready;
  reservation_station_t                issue_entry;
  logic [$clog2(DEPTH):0]              occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_entry, dispatch_rs1_rdy, dispatch_rs2_rdy,
           dispatch_rs1_tag, dispatch_rs2_tag, cdb_valid, cdb_rob_idx, cdb_data, issue_ready,
    input  dispatch_ready, issue_valid, issue_entry, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_entry, dispatch_rs1_rdy, dispatch_rs2_rdy,
           dispatch_rs1_tag, dispatch_rs2_tag, cdb_valid, cdb_rob_idx, cdb_data, issue_ready,
    output dispatch_ready, issue_valid, issue_entry, occupancy
  );

endinterface

// File: rtl/alu_issue_queue_age_matrix_select.sv
// Age matrix with oldest-first one-hot select; r_age[i][j]=1 means entry i is older than j.
// Shared by all issue queues, so it knows nothing about the payload.
module age_matrix_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_age [DEPTH];

  // A new entry becomes younger than everything; stale bits towards empty slots are overwritten on their next alloc.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i_alloc[i])                 r_age[i][j] <= 1'b0;
          else if (i_alloc[j])            r_age[i][j] <= 1'b1;
          else if (i_free[i] || i_free[j]) r_age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (i_req[j] && r_age[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds renamed ops until CDB wakeup, then issues the
// oldest ready one through a single registered, stallable slot.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = RS_TAG_W,
  parameter int NUM_CDB   = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_queue_if.slave io_bus
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  alu_rs_entry_t        r_entries [DEPTH];
  alu_rs_entry_t        w_next    [DEPTH];
  alu_rs_entry_t        w_new;
  reservation_station_t r_issue_entry;
  reservation_station_t w_pick;
  logic                 r_issue_valid;
  logic [OCC_W-1:0]     r_occupancy;
  cdb_t                 w_cdb [NUM_CDB];
  logic [DEPTH-1:0]     w_valid, w_req, w_grant, w_alloc, w_alloc_acc, w_free;
  logic                 w_accept, w_load, w_slot_open;
  logic [ROB_IDX_W-1:0] w_rs1_tag, w_rs2_tag;

  assign w_rs1_tag = io_bus.dispatch_rs1_tag;
  assign w_rs2_tag = io_bus.dispatch_rs2_tag;

  for (genvar p = 0; p < NUM_CDB; p++) begin : g_cdb
    assign w_cdb[p] = '{valid:   io_bus.cdb_valid[p],
                        rob_idx: io_bus.cdb_rob_idx[p],
                        data:    io_bus.cdb_data[p]};
  end

  always_comb begin
    w_valid = '0;
    w_req   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_entries[i].rs.valid;
      w_req[i]   = r_entries[i].rs.valid && r_entries[i].rs1_rdy && r_entries[i].rs2_rdy;
    end
  end

  assign io_bus.dispatch_ready = (r_occupancy < OCC_W'(DEPTH));
  assign w_accept    = io_bus.dispatch_valid && io_bus.dispatch_ready && !io_bus.flush;
  assign w_alloc     = ~w_valid & (w_valid + DEPTH'(1));
  assign w_alloc_acc = w_accept ? w_alloc : '0;
  assign w_slot_open = !r_issue_valid || io_bus.issue_ready;
  assign w_load      = w_slot_open && (|w_grant) && !io_bus.flush;
  assign w_free      = w_load ? w_grant : '0;

  age_matrix_select #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_alloc (w_alloc_acc),
    .i_free  (w_free),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  // Descending port scan so the lowest-index matching port is the one that sticks.
  always_comb begin
    w_new            = '0;
    w_new.rs         = io_bus.dispatch_entry;
    w_new.rs.valid   = 1'b1;
    w_new.rs1_rdy    = io_bus.dispatch_rs1_rdy;
    w_new.rs2_rdy    = io_bus.dispatch_rs2_rdy;
    w_new.rs1_tag    = w_rs1_tag;
    w_new.rs2_tag    = w_rs2_tag;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (!io_bus.dispatch_rs1_rdy && cdb_hit(w_cdb[p], w_rs1_tag)) begin
        w_new.rs1_rdy     = 1'b1;
        w_new.rs.rs1_data = w_cdb[p].data;
      end
      if (!io_bus.dispatch_rs2_rdy && cdb_hit(w_cdb[p], w_rs2_tag)) begin
        w_new.rs2_rdy     = 1'b1;
        w_new.rs.rs2_data = w_cdb[p].data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = r_entries[i];
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (!r_entries[i].rs1_rdy && cdb_hit(w_cdb[p], r_entries[i].rs1_tag)) begin
          w_next[i].rs1_rdy     = 1'b1;
          w_next[i].rs.rs1_data = w_cdb[p].data;
        end
        if (!r_entries[i].rs2_rdy && cdb_hit(w_cdb[p], r_entries[i].rs2_tag)) begin
          w_next[i].rs2_rdy     = 1'b1;
          w_next[i].rs.rs2_data = w_cdb[p].data;
        end
      end
      if (w_free[i])      w_next[i].rs.valid = 1'b0;
      if (w_alloc_acc[i]) w_next[i] = w_new;
    end
  end

  always_comb begin
    w_pick = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_pick = r_entries[i].rs;
    end
    w_pick.valid = 1'b1;
  end

  // Reset and flush have the same effect on every register here.
  always_ff @(posedge clk) begin
    if (rst || io_bus.flush) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_issue_valid <= 1'b0;
      r_issue_entry <= '0;
      r_occupancy   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= w_next[i];
      if (w_load) begin
        r_issue_valid <= 1'b1;
        r_issue_entry <= w_pick;
      end else if (r_issue_valid && io_bus.issue_ready) begin
        r_issue_valid <= 1'b0;
        r_issue_entry <= '0;
      end
      r_occupancy <= r_occupancy + OCC_W'(w_accept) - OCC_W'(w_load);
    end
  end

  assign io_bus.issue_valid = r_issue_valid;
  assign io_bus.issue_entry = r_issue_entry;
  assign io_bus.occupancy   = r_occupancy;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against an in-order
// list model: pending ops kept oldest-first, plus one issue slot.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int NCDB  = 2;
  localparam int TW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(DEPTH), .ROB_IDX_W(TW), .NUM_CDB(NCDB)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .ROB_IDX_W(TW), .NUM_CDB(NCDB)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic                      s_dv, s_r1, s_r2, s_ir, s_fl, s_rst;
  reservation_station_t      s_entry;
  logic [TW-1:0]             s_t1, s_t2;
  logic [NCDB-1:0]           s_cv;
  logic [NCDB-1:0][TW-1:0]   s_ci;
  logic [NCDB-1:0][31:0]     s_cd;

  alu_rs_entry_t        mq[$];
  logic                 m_sv;
  reservation_station_t m_se;

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic setIdle();
    s_dv = 1'b0; s_entry = '0; s_r1 = 1'b1; s_r2 = 1'b1; s_t1 = '0; s_t2 = '0;
    s_cv = '0; s_ci = '0; s_cd = '0; s_ir = 1'b1; s_fl = 1'b0; s_rst = 1'b0;
  endtask

  task automatic setDispatch(input logic [TW-1:0] id, input logic r1, input logic r2,
                             input logic [TW-1:0] t1, input logic [TW-1:0] t2);
    s_dv = 1'b1; s_r1 = r1; s_r2 = r2; s_t1 = t1; s_t2 = t2;
    s_entry.valid    = 1'($urandom);
    s_entry.op       = alu_op_e'($urandom_range(0, 9));
    s_entry.rob_idx  = id;
    s_entry.rd       = 5'($urandom);
    s_entry.rs1_data = $urandom;
    s_entry.rs2_data = $urandom;
  endtask

  task automatic drive();
    rst                   = s_rst;
    bus.flush             = s_fl;
    bus.dispatch_valid    = s_dv;
    bus.dispatch_entry    = s_entry;
    bus.dispatch_rs1_rdy  = s_r1;
    bus.dispatch_rs2_rdy  = s_r2;
    bus.dispatch_rs1_tag  = s_t1;
    bus.dispatch_rs2_tag  = s_t2;
    bus.cdb_valid         = s_cv;
    bus.cdb_rob_idx       = s_ci;
    bus.cdb_data          = s_cd;
    bus.issue_ready       = s_ir;
  endtask

  // Returns {ready, data} after snooping this cycle's broadcasts; first matching port wins.
  function automatic logic [32:0] wake(input logic rdy, input logic [TW-1:0] tag, input logic [31:0] data);
    logic [32:0] r;
    r = {rdy, data};
    for (int p = 0; p < NCDB; p++) begin
      if (!r[32] && s_cv[p] && s_ci[p] == tag) r = {1'b1, s_cd[p]};
    end
    return r;
  endfunction

  task automatic applyStimulus();
    int            pick;
    logic          acc;
    logic [32:0]   w;
    alu_rs_entry_t n;
    drive();
    #1;
    checkOutput("dispatch_ready", bus.dispatch_ready, mq.size() < DEPTH);
    checkOutput("occupancy", bus.occupancy, mq.size());
    checkOutput("issue_valid", bus.issue_valid, m_sv);
    if (m_sv) checkOutput("issue_entry", bus.issue_entry, m_se);
    if (s_rst || s_fl) begin
      mq.delete();
      m_sv = 1'b0;
      m_se = '0;
    end else begin
      pick = -1;
      for (int k = 0; k < mq.size(); k++) begin
        if (pick < 0 && mq[k].rs1_rdy && mq[k].rs2_rdy) pick = k;
      end
      acc = s_dv && (mq.size() < DEPTH);
      for (int k = 0; k < mq.size(); k++) begin
        n = mq[k];
        w = wake(n.rs1_rdy, n.rs1_tag, n.rs.rs1_data);
        n.rs1_rdy = w[32]; n.rs.rs1_data = w[31:0];
        w = wake(n.rs2_rdy, n.rs2_tag, n.rs.rs2_data);
        n.rs2_rdy = w[32]; n.rs.rs2_data = w[31:0];
        mq[k] = n;
      end
      if ((!m_sv || s_ir) && pick >= 0) begin
        m_se = mq[pick].rs;
        m_se.valid = 1'b1;
        m_sv = 1'b1;
        mq.delete(pick);
      end else if (m_sv && s_ir) begin
        m_sv = 1'b0;
      end
      if (acc) begin
        n = '0;
        n.rs = s_entry;
        n.rs.valid = 1'b1;
        n.rs1_tag = s_t1;
        n.rs2_tag = s_t2;
        w = wake(s_r1, s_t1, s_entry.rs1_data);
        n.rs1_rdy = w[32]; n.rs.rs1_data = w[31:0];
        w = wake(s_r2, s_t2, s_entry.rs2_data);
        n.rs2_rdy = w[32]; n.rs.rs2_data = w[31:0];
        mq.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    setIdle();
    s_rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete();
    m_sv = 1'b0;
    m_se = '0;
    setIdle();
    drive();
    #1;
    checkOutput("reset_issue_valid", bus.issue_valid, 1'b0);
    checkOutput("reset_occupancy", bus.occupancy, 0);
    checkOutput("reset_dispatch_ready", bus.dispatch_ready, 1'b1);
    checkOutput("reset_issue_entry", bus.issue_entry, 0);
    @(negedge clk);

    // Three ready ops back to back
    for (int i = 0; i < 3; i++) begin
      setIdle(); setDispatch(TW'(i), 1'b1, 1'b1, '0, '0); applyStimulus();
    end
    setIdle();
    repeat (3) applyStimulus();

    // A waits on tag 5 while younger B issues first
    setIdle(); setDispatch(5'd10, 1'b0, 1'b1, 5'd5, '0); applyStimulus();
    setIdle(); setDispatch(5'd11, 1'b1, 1'b1, '0, '0); applyStimulus();
    setIdle(); s_cv = 2'b01; s_ci[0] = 5'd5; s_cd[0] = 32'h1234; applyStimulus();
    setIdle(); applyStimulus();
    checkOutput("wake_issue_valid", bus.issue_valid, 1'b1);
    checkOutput("wake_rob_idx", bus.issue_entry.rob_idx, 5'd10);
    checkOutput("wake_rs1_data", bus.issue_entry.rs1_data, 32'h1234);
    setIdle();
    repeat (3) applyStimulus();

    // Same-cycle bypass on CDB port 1
    setIdle(); setDispatch(5'd12, 1'b1, 1'b0, '0, 5'd9);
    s_cv = 2'b10; s_ci[1] = 5'd9; s_cd[1] = 32'hDEAD; applyStimulus();
    setIdle(); applyStimulus();
    checkOutput("bypass_issue_valid", bus.issue_valid, 1'b1);
    checkOutput("bypass_rs2_data", bus.issue_entry.rs2_data, 32'hDEAD);
    setIdle();
    repeat (2) applyStimulus();

    // Fill under backpressure, then drain oldest-first
    for (int i = 0; i < 9; i++) begin
      setIdle(); s_ir = 1'b0; setDispatch(TW'(i + 16), 1'b1, 1'b1, '0, '0); applyStimulus();
    end
    checkOutput("full_dispatch_ready", bus.dispatch_ready, 1'b0);
    checkOutput("full_occupancy", bus.occupancy, DEPTH);
    for (int i = 0; i < 3; i++) begin
      setIdle(); s_ir = 1'b0; setDispatch(5'd30, 1'b1, 1'b1, '0, '0); applyStimulus();
    end
    setIdle();
    repeat (11) applyStimulus();

    // Flush with five entries, a held slot and a concurrent dispatch
    for (int i = 0; i < 6; i++) begin
      setIdle(); s_ir = 1'b0; setDispatch(TW'(i), 1'b1, 1'b1, '0, '0); applyStimulus();
    end
    setIdle(); s_ir = 1'b0; setDispatch(5'd25, 1'b1, 1'b1, '0, '0); s_fl = 1'b1; applyStimulus();
    setIdle();
    drive();
    #1;
    checkOutput("flush_occupancy", bus.occupancy, 0);
    checkOutput("flush_issue_valid", bus.issue_valid, 1'b0);
    checkOutput("flush_dispatch_ready", bus.dispatch_ready, 1'b1);
    @(negedge clk);
    repeat (2) applyStimulus();

    // Reset while the slot is stalled
    for (int i = 0; i < 5; i++) begin
      setIdle(); s_ir = 1'b0; setDispatch(TW'(i), 1'b1, 1'b1, '0, '0); applyStimulus();
    end
    setIdle(); s_ir = 1'b0; s_rst = 1'b1; applyStimulus();
    setIdle();
    drive();
    #1;
    checkOutput("rst_issue_valid", bus.issue_valid, 1'b0);
    checkOutput("rst_issue_entry", bus.issue_entry, 0);
    checkOutput("rst_occupancy", bus.occupancy, 0);
    checkOutput("rst_dispatch_ready", bus.dispatch_ready, 1'b1);
    @(negedge clk);

    // Random traffic with a small tag space so wakeups are frequent
    for (int c = 0; c < 3000; c++) begin
      setIdle();
      s_ir = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        setDispatch(TW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)));
      for (int p = 0; p < NCDB; p++) begin
        s_cv[p] = ($urandom_range(0, 2) == 0);
        s_ci[p] = TW'($urandom_range(0, 7));
        s_cd[p] = $urandom;
      end
      s_fl  = ($urandom_range(0, 99) == 0);
      s_rst = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
